// File: rtl/regfile_pkg.sv
// Shared widths, FSM state type and the RAM address/lane helpers for the
// 32-entry register file built on two dual-port RAM banks.
package regfile_pkg;

    localparam int REG_IDX_W  = 5;
    localparam int MEM_ADDR_W = 14;
    localparam int MEM_DATA_W = 36;
    localparam int NREGS      = 32;

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    // Word address in [13:4], byte enables in [1:0] (both lanes on).
    function automatic logic [MEM_ADDR_W-1:0] build_addr(input logic [REG_IDX_W-1:0] idx);
        return {5'b0, idx, 2'b00, 2'b11};
    endfunction

    // x18 mode: each 16-bit half sits in the low bits of an 18-bit lane.
    function automatic logic [MEM_DATA_W-1:0] pack_lanes(input logic [31:0] d);
        return {2'b0, d[31:16], 2'b0, d[15:0]};
    endfunction

    function automatic logic [31:0] unpack_lanes(input logic [MEM_DATA_W-1:0] q);
        return {q[33:18], q[15:0]};
    endfunction

endpackage

// File: rtl/regfile_dpram_ctrl_if.sv
// Request/response bus between a pipeline and the register-file controller.
interface regfile_dpram_ctrl_if;
    import regfile_pkg::*;

    logic                 rd_en;
    logic [REG_IDX_W-1:0] rs1_idx;
    logic [REG_IDX_W-1:0] rs2_idx;
    logic [31:0]          rs1_data;
    logic [31:0]          rs2_data;
    logic                 rd_valid;
    logic                 wr_en;
    logic [REG_IDX_W-1:0] wr_idx;
    logic [31:0]          wr_data;
    logic                 ready;

    modport master (
        output rd_en, rs1_idx, rs2_idx, wr_en, wr_idx, wr_data,
        input  rs1_data, rs2_data, rd_valid, ready
    );

    modport slave (
        input  rd_en, rs1_idx, rs2_idx, wr_en, wr_idx, wr_data,
        output rs1_data, rs2_data, rd_valid, ready
    );

endinterface

// File: rtl/regfile_dpram_ctrl.sv
// Register-file controller: zero-fills two RAM banks after reset, then serves
// two reads and one write per cycle with same-cycle write-to-read bypass.
module regfile_dpram_ctrl
    import regfile_pkg::*;
#(
    parameter int INIT_ZERO = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    regfile_dpram_ctrl_if.slave   bus,
    output logic                  mem_wr_en,
    output logic [MEM_ADDR_W-1:0] mem_wr_addr,
    output logic [MEM_DATA_W-1:0] mem_wr_data,
    output logic [MEM_ADDR_W-1:0] mem_rd1_addr,
    output logic [MEM_ADDR_W-1:0] mem_rd2_addr,
    input  logic [MEM_DATA_W-1:0] mem_rd1_q,
    input  logic [MEM_DATA_W-1:0] mem_rd2_q,
    output logic                  mem_ce
);

    state_e               state_q;
    logic [REG_IDX_W-1:0] cnt_q;
    logic                 ready_q;
    logic                 rd_valid_q;
    logic                 zero1_q, zero2_q;
    logic                 byp1_q, byp2_q;
    logic [31:0]          byp_data_q;
    logic [31:0]          hold1_q, hold2_q;

    logic                 run;
    logic                 rd_acc;
    logic                 wr_acc;
    logic [31:0]          rs1_res, rs2_res;

    assign run    = (state_q == RUN) && !rst_i;
    assign rd_acc = run && bus.rd_en;
    assign wr_acc = run && bus.wr_en && (bus.wr_idx != '0);

    always_comb begin
        mem_wr_en   = 1'b0;
        mem_wr_addr = build_addr(bus.wr_idx);
        mem_wr_data = pack_lanes(bus.wr_data);
        if (!rst_i && state_q == INIT) begin
            mem_wr_en   = 1'b1;
            mem_wr_addr = build_addr(cnt_q);
            mem_wr_data = '0;
        end else if (wr_acc) begin
            mem_wr_en   = 1'b1;
        end
    end

    assign mem_rd1_addr = build_addr(bus.rs1_idx);
    assign mem_rd2_addr = build_addr(bus.rs2_idx);
    assign mem_ce       = 1'b1;

    // RAM data arrives the cycle after the request, so resolution happens there.
    always_comb begin
        rs1_res = zero1_q ? 32'h0 : (byp1_q ? byp_data_q : unpack_lanes(mem_rd1_q));
        rs2_res = zero2_q ? 32'h0 : (byp2_q ? byp_data_q : unpack_lanes(mem_rd2_q));
    end

    assign bus.rs1_data = rd_valid_q ? rs1_res : hold1_q;
    assign bus.rs2_data = rd_valid_q ? rs2_res : hold2_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.ready    = ready_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= (INIT_ZERO != 0) ? INIT : RUN;
            ready_q    <= (INIT_ZERO == 0);
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            zero1_q    <= 1'b0;
            zero2_q    <= 1'b0;
            byp1_q     <= 1'b0;
            byp2_q     <= 1'b0;
            hold1_q    <= '0;
            hold2_q    <= '0;
        end else begin
            case (state_q)
                INIT: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'(NREGS - 1)) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                default: ;
            endcase
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                zero1_q    <= (bus.rs1_idx == '0);
                zero2_q    <= (bus.rs2_idx == '0);
                byp1_q     <= bus.wr_en && (bus.wr_idx == bus.rs1_idx);
                byp2_q     <= bus.wr_en && (bus.wr_idx == bus.rs2_idx);
                byp_data_q <= bus.wr_data;
            end
            if (rd_valid_q) begin
                hold1_q <= rs1_res;
                hold2_q <= rs2_res;
            end
        end
    end

endmodule

// File: tb/tb_regfile_dpram_ctrl.sv
// Scoreboard bench for regfile_dpram_ctrl with behavioural RAM banks.
module tb_regfile_dpram_ctrl;
    import regfile_pkg::*;

    typedef struct packed {
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] stamp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_dpram_ctrl_if bus();

    logic        mem_wr_en, mem_ce;
    logic [13:0] mem_wr_addr, mem_rd1_addr, mem_rd2_addr;
    logic [35:0] mem_wr_data, mem_rd1_q, mem_rd2_q;

    regfile_dpram_ctrl #(.INIT_ZERO(1)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd1_addr(mem_rd1_addr),
        .mem_rd2_addr(mem_rd2_addr),
        .mem_rd1_q   (mem_rd1_q),
        .mem_rd2_q   (mem_rd2_q),
        .mem_ce      (mem_ce)
    );

    // Two banks sharing port A; read returns the pre-write contents.
    logic [35:0] bank1 [0:1023] = '{default: 36'h5_A5A5_A5A5};
    logic [35:0] bank2 [0:1023] = '{default: 36'h5_A5A5_A5A5};
    always @(posedge clk) begin
        if (mem_ce) begin
            mem_rd1_q <= bank1[mem_rd1_addr[13:4]];
            mem_rd2_q <= bank2[mem_rd2_addr[13:4]];
            if (mem_wr_en) begin
                bank1[mem_wr_addr[13:4]] <= mem_wr_data;
                bank2[mem_wr_addr[13:4]] <= mem_wr_data;
            end
        end
    end

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          acc_rd = 0;
    int          vld_cnt = 0;
    exp_t        sbq[$];
    exp_t        mon_e;
    logic [31:0] ref_regs [0:31];

    logic        s_wen, s_vld, s_ready;
    logic [13:0] s_waddr;
    logic [35:0] s_wdata;
    logic [31:0] s_rs1;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rd_valid pops one expectation.
    initial forever begin
        @(negedge clk);
        if (bus.rd_valid === 1'b1) begin
            vld_cnt++;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_valid_unexpected: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk("rs1_data", 64'(bus.rs1_data), 64'(mon_e.e1));
                chk("rs2_data", 64'(bus.rs2_data), 64'(mon_e.e2));
                chk("rd_latency", 64'(cyc), 64'(mon_e.stamp + 32'd1));
            end
        end
    end

    // One clock cycle of stimulus, entered and left at posedge+1.
    task automatic drive(input logic rd, input logic [4:0] r1, input logic [4:0] r2,
                         input logic wr, input logic [4:0] wi, input logic [31:0] wd,
                         input logic r);
        exp_t e;
        rst         = r;
        bus.rd_en   = rd;
        bus.rs1_idx = r1;
        bus.rs2_idx = r2;
        bus.wr_en   = wr;
        bus.wr_idx  = wi;
        bus.wr_data = wd;
        if (!r && bus.ready === 1'b1) begin
            if (rd) begin
                e.e1    = (r1 == 0) ? 32'h0 : ((wr && wi == r1) ? wd : ref_regs[r1]);
                e.e2    = (r2 == 0) ? 32'h0 : ((wr && wi == r2) ? wd : ref_regs[r2]);
                e.stamp = cyc;
                sbq.push_back(e);
                acc_rd++;
            end
            if (wr && wi != 0) ref_regs[wi] = wd;
        end
        @(negedge clk);
        s_wen   = mem_wr_en;
        s_waddr = mem_wr_addr;
        s_wdata = mem_wr_data;
        s_vld   = bus.rd_valid;
        s_ready = bus.ready;
        s_rs1   = bus.rs1_data;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0);
    endtask

    // Full 32-cycle fill with requests driven that must be ignored.
    task automatic run_fill();
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 5'd5, 5'd9, 1'b1, 5'd9, 32'hCAFE_F00D, 1'b0);
            chk("fill_wen", 64'(s_wen), 64'd1);
            chk("fill_addr", 64'(s_waddr), 64'((i << 4) | 3));
            chk("fill_data", 64'(s_wdata), 64'd0);
            chk("fill_ready", 64'(s_ready), 64'd0);
        end
        chk("ready_after_fill", 64'(bus.ready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
        bus.rd_en = 1'b0; bus.rs1_idx = '0; bus.rs2_idx = '0;
        bus.wr_en = 1'b0; bus.wr_idx = '0;  bus.wr_data = '0;
        @(posedge clk);
        #1;

        drive(1'b1, 5'd3, 5'd3, 1'b1, 5'd9, 32'h1234_0000, 1'b1);
        chk("wen_in_reset", 64'(s_wen), 64'd0);
        chk("rst_ready", 64'(bus.ready), 64'd0);
        chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("rst_rs1", 64'(bus.rs1_data), 64'd0);
        chk("rst_rs2", 64'(bus.rs2_data), 64'd0);
        run_fill();

        drive(1'b1, 5'd5, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0);

        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0);
        chk("wr3_wen", 64'(s_wen), 64'd1);
        chk("wr3_addr", 64'(s_waddr), 64'h033);
        chk("wr3_data", 64'(s_wdata), 64'h3_7AB4_BEEF);
        idle();
        drive(1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0);
        chk("rd3_no_vld_yet", 64'(s_vld), 64'd0);
        idle();
        chk("rd3_vld_next", 64'(s_vld), 64'd1);
        chk("rd3_data", 64'(s_rs1), 64'hDEAD_BEEF);
        idle();
        chk("hold_vld", 64'(s_vld), 64'd0);
        chk("hold_rs1", 64'(s_rs1), 64'hDEAD_BEEF);

        drive(1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 32'h1234_5678, 1'b0);
        chk("wr7_addr", 64'(s_waddr), 64'h073);
        drive(1'b1, 5'd3, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
        chk("wr0_dropped", 64'(s_wen), 64'd0);
        drive(1'b1, 5'd0, 5'd7, 1'b1, 5'd31, 32'h8000_0001, 1'b0);
        chk("wr31_addr", 64'(s_waddr), 64'h1F3);
        chk("wr31_data", 64'(s_wdata), 64'h2_0000_0001);
        drive(1'b1, 5'd31, 5'd31, 1'b0, 5'd0, 32'h0, 1'b0);

        // Reset with a read request in the same cycle: that read is dropped.
        drive(1'b1, 5'd3, 5'd3, 1'b1, 5'd4, 32'h0000_AAAA, 1'b1);
        chk("wen_in_reset2", 64'(s_wen), 64'd0);
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd1, 32'h5555_5555, 1'b0);
            chk("part_fill_addr", 64'(s_waddr), 64'((i << 4) | 3));
        end
        drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd1, 32'h5555_5555, 1'b1);
        chk("wen_in_reset3", 64'(s_wen), 64'd0);
        run_fill();

        for (int n = 0; n < 2000; n++) begin
            drive(1'($urandom_range(0, 3) != 0),
                  5'((n % 2 == 0) ? $urandom_range(0, 7) : $urandom_range(0, 31)),
                  5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 2) != 0),
                  5'($urandom_range(0, 7)),
                  $urandom, 1'b0);
        end
        idle();
        idle();
        chk("vld_count", 64'(vld_cnt), 64'(acc_rd));
        chk("queue_empty", 64'(sbq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
